// File: rtl/inertial_pkg.sv
// rtl/inertial_pkg.sv - shared state enum, default tuning constants and saturating adder
package inertial_pkg;

  typedef enum logic {
    ST_CAL = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  localparam logic [15:0] AZ_OFFSET_DEF  = 16'h00A0;
  localparam int          AZ_SCALE_DEF   = 327;
  localparam int          PROD_SHIFT_DEF = 13;
  localparam int          FUSE_MAG_DEF   = 1024;

  // a+b clamped to the signed range of a w-bit word (w <= 62)
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int              w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) begin
      sat_add = hi;
    end else if (s < lo) begin
      sat_add = lo;
    end else begin
      sat_add = s;
    end
  endfunction

endpackage

// File: rtl/inertial_integrator_cal_if.sv
// rtl/inertial_integrator_cal_if.sv - sample/control bundle between sensor front end and integrator
interface inertial_integrator_cal_if #(
  parameter int DATA_W = 16
);
  logic                     vld;
  logic signed [DATA_W-1:0] ptch_rt;
  logic signed [DATA_W-1:0] AZ;
  logic                     fuse_en;
  logic                     cal_req;
  logic signed [DATA_W-1:0] ptch;
  logic                     ptch_vld;
  logic                     cal_done;
  logic signed [DATA_W-1:0] bias;

  modport master (
    output vld, ptch_rt, AZ, fuse_en, cal_req,
    input  ptch, ptch_vld, cal_done, bias
  );

  modport slave (
    input  vld, ptch_rt, AZ, fuse_en, cal_req,
    output ptch, ptch_vld, cal_done, bias
  );
endinterface

// File: rtl/inertial_integrator_cal_gyro_bias_cal.sv
// rtl/inertial_integrator_cal_gyro_bias_cal.sv - averages 2^CAL_LOG2 gyro samples into a bias word
module gyro_bias_cal #(
  parameter int DATA_W   = 16,
  parameter int CAL_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     vld_i,
  input  logic signed [DATA_W-1:0] ptch_rt_i,
  output logic signed [DATA_W-1:0] bias_o,
  output logic                     done_pulse_o
);

  localparam int SUM_W = DATA_W + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << CAL_LOG2) - 1);

  logic signed [SUM_W-1:0]  sum_q, sum_d, sum_next, rt_ext;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic                     last_sample;

  assign rt_ext      = {{CAL_LOG2{ptch_rt_i[DATA_W-1]}}, ptch_rt_i};
  assign sum_next    = sum_q + rt_ext;
  assign last_sample = vld_i && !clear_i && (cnt_q == LAST_CNT);

  always_comb begin
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    bias_d = bias_q;
    if (clear_i) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (vld_i) begin
      if (cnt_q == LAST_CNT) begin
        // floor average; the sum restarts so a later recalibration begins clean
        bias_d = DATA_W'(sum_next >>> CAL_LOG2);
        sum_d  = '0;
        cnt_d  = '0;
      end else begin
        sum_d = sum_next;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cnt_q  <= '0;
      bias_q <= '0;
    end else begin
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      bias_q <= bias_d;
    end
  end

  assign bias_o       = bias_q;
  assign done_pulse_o = last_sample;

endmodule

// File: rtl/inertial_integrator_cal.sv
// rtl/inertial_integrator_cal.sv - gyro/accel pitch integrator with run-time bias calibration
// INERT_SAT_EN: clamp the integrator instead of letting it wrap.
module inertial_integrator_cal
  import inertial_pkg::*;
#(
  parameter int              DATA_W     = 16,
  parameter int              FRAC_W     = 11,
  parameter int              CAL_LOG2   = 8,
  parameter logic [DATA_W-1:0] AZ_OFFSET = AZ_OFFSET_DEF,
  parameter int              AZ_SCALE   = AZ_SCALE_DEF,
  parameter int              PROD_SHIFT = PROD_SHIFT_DEF,
  parameter int              FUSE_MAG   = FUSE_MAG_DEF
) (
  input logic                         clk,
  input logic                         rst,
  inertial_integrator_cal_if.slave    bus
);

  localparam int ACC_W  = DATA_W + FRAC_W;
  localparam int PROD_W = DATA_W + 1 + 32;
  localparam logic signed [PROD_W-1:0] SCALE_W  = PROD_W'(AZ_SCALE);
  localparam logic signed [ACC_W-1:0]  FUSE_POS = ACC_W'(FUSE_MAG);
  localparam logic signed [ACC_W-1:0]  FUSE_NEG = -FUSE_POS;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  ptch_int_q, ptch_int_d, ptch_int_upd;
  logic                     ptch_vld_q, ptch_vld_d;
  logic                     cal_done_q;
  logic signed [DATA_W-1:0] ptch_cur, bias_cur, acc_p;
  logic signed [DATA_W:0]   rt_comp, az_comp;
  logic signed [PROD_W-1:0] az_prod;
  logic signed [ACC_W-1:0]  fuse_v, rt_ext;
  logic                     cal_sample, cal_finish;

  assign ptch_cur   = $signed(ptch_int_q[ACC_W-1:FRAC_W]);
  assign cal_sample = bus.vld && (state_q == ST_CAL) && !bus.cal_req;

  gyro_bias_cal #(
    .DATA_W   (DATA_W),
    .CAL_LOG2 (CAL_LOG2)
  ) u_bias_cal (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (bus.cal_req),
    .vld_i        (cal_sample),
    .ptch_rt_i    (bus.ptch_rt),
    .bias_o       (bias_cur),
    .done_pulse_o (cal_finish)
  );

  // one extra bit on both differences keeps them exact for any input/bias pair
  assign rt_comp = {bus.ptch_rt[DATA_W-1], bus.ptch_rt} - {bias_cur[DATA_W-1], bias_cur};
  assign az_comp = {bus.AZ[DATA_W-1], bus.AZ} - {AZ_OFFSET[DATA_W-1], AZ_OFFSET};
  assign az_prod = {{(PROD_W-DATA_W-1){az_comp[DATA_W]}}, az_comp} * SCALE_W;
  assign acc_p   = DATA_W'(az_prod >>> PROD_SHIFT);
  assign rt_ext  = {{(ACC_W-DATA_W-1){rt_comp[DATA_W]}}, rt_comp};

  always_comb begin
    fuse_v = '0;
    if (bus.fuse_en) begin
      fuse_v = (acc_p > ptch_cur) ? FUSE_POS : FUSE_NEG;
    end
  end

`ifdef INERT_SAT_EN
  logic signed [ACC_W+1:0] step_w;

  assign step_w = {{2{fuse_v[ACC_W-1]}}, fuse_v} - {{2{rt_ext[ACC_W-1]}}, rt_ext};

  always_comb begin
    ptch_int_upd = ACC_W'(sat_add(64'(ptch_int_q), 64'(step_w), ACC_W));
  end
`else
  always_comb begin
    ptch_int_upd = ptch_int_q - rt_ext + fuse_v;
  end
`endif

  always_comb begin
    state_d    = state_q;
    ptch_int_d = ptch_int_q;
    ptch_vld_d = 1'b0;
    if (bus.cal_req) begin
      state_d    = ST_CAL;
      ptch_int_d = '0;
    end else begin
      unique case (state_q)
        ST_CAL: begin
          ptch_int_d = '0;
          if (cal_finish) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.vld) begin
            ptch_int_d = ptch_int_upd;
            ptch_vld_d = 1'b1;
          end
        end
        default: state_d = ST_CAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CAL;
      ptch_int_q <= '0;
      ptch_vld_q <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptch_int_q <= ptch_int_d;
      ptch_vld_q <= ptch_vld_d;
      cal_done_q <= (state_d == ST_RUN);
    end
  end

  assign bus.ptch     = ptch_cur;
  assign bus.ptch_vld = ptch_vld_q;
  assign bus.cal_done = cal_done_q;
  assign bus.bias     = bias_cur;

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// tb/tb_inertial_integrator_cal.sv - directed vector bench for inertial_integrator_cal (CAL_LOG2=4)
module tb_inertial_integrator_cal;

  typedef struct {
    logic        vld;
    logic [15:0] rt;
    logic [15:0] az;
    logic        fuse;
    logic        req;
    logic [15:0] e_ptch;
    logic        e_vld;
    logic        e_done;
    logic [15:0] e_bias;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  inertial_integrator_cal_if #(.DATA_W(16)) bus();

  inertial_integrator_cal #(
    .CAL_LOG2 (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [15:0] rt, input logic [15:0] az,
                              input logic f, input logic r, input logic [15:0] ep,
                              input logic ev, input logic ed, input logic [15:0] eb);
    vec_t x;
    x.vld = v; x.rt = rt; x.az = az; x.fuse = f; x.req = r;
    x.e_ptch = ep; x.e_vld = ev; x.e_done = ed; x.e_bias = eb;
    tbl.push_back(x);
  endfunction

  task automatic apply(input vec_t x, input string tag);
    bus.vld     = x.vld;
    bus.ptch_rt = x.rt;
    bus.AZ      = x.az;
    bus.fuse_en = x.fuse;
    bus.cal_req = x.req;
    @(posedge clk);
    #1;
    chk({tag, " ptch"},     bus.ptch,            x.e_ptch);
    chk({tag, " ptch_vld"}, {15'd0, bus.ptch_vld}, {15'd0, x.e_vld});
    chk({tag, " cal_done"}, {15'd0, bus.cal_done}, {15'd0, x.e_done});
    chk({tag, " bias"},     bus.bias,            x.e_bias);
  endtask

  initial begin
    vec_t     v;
    longint   m;
    longint   acc_max;
    logic [15:0] ep;

    rst = 1'b1;
    bus.vld = 1'b0; bus.ptch_rt = '0; bus.AZ = '0; bus.fuse_en = 1'b0; bus.cal_req = 1'b0;
    @(posedge clk);
    #1;
    chk("reset ptch",     bus.ptch, 16'h0000);
    chk("reset ptch_vld", {15'd0, bus.ptch_vld}, 16'h0000);
    chk("reset cal_done", {15'd0, bus.cal_done}, 16'h0000);
    chk("reset bias",     bus.bias, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      add(1, 16'h0050, 16'h00A0, 0, 0, 16'h0000, 0, (i == 15), (i == 15) ? 16'h0050 : 16'h0000);
    for (int i = 0; i < 100; i++)
      add(1, 16'h0050, 16'h00A0, 0, 0, 16'h0000, 1, 1, 16'h0050);
    add(0, 16'h0050, 16'h00A0, 0, 0, 16'h0000, 0, 1, 16'h0050);
    add(1, 16'h0850, 16'h00A0, 0, 0, 16'hFFFF, 1, 1, 16'h0050);
    add(0, 16'h0850, 16'h00A0, 0, 0, 16'hFFFF, 0, 1, 16'h0050);
    add(1, 16'hF850, 16'h00A0, 0, 0, 16'h0000, 1, 1, 16'h0050);
    add(1, 16'h0050, 16'h10A0, 1, 0, 16'h0000, 1, 1, 16'h0050);
    add(1, 16'h0050, 16'h10A0, 1, 0, 16'h0001, 1, 1, 16'h0050);
    add(1, 16'h0050, 16'h00A0, 1, 0, 16'h0000, 1, 1, 16'h0050);
    add(1, 16'h0050, 16'h00A0, 1, 0, 16'h0000, 1, 1, 16'h0050);
    add(1, 16'h0050, 16'h00A0, 1, 0, 16'hFFFF, 1, 1, 16'h0050);
    add(1, 16'h0050, 16'h00A0, 1, 0, 16'h0000, 1, 1, 16'h0050);
    add(1, 16'h0050, 16'hF0A0, 1, 0, 16'hFFFF, 1, 1, 16'h0050);
    add(1, 16'h0050, 16'hF0A0, 1, 0, 16'hFFFF, 1, 1, 16'h0050);
    add(1, 16'h0050, 16'hF0A0, 1, 0, 16'hFFFE, 1, 1, 16'h0050);
    add(0, 16'h0050, 16'h10A0, 1, 0, 16'hFFFE, 0, 1, 16'h0050);
    add(1, 16'h0850, 16'h00A0, 0, 1, 16'h0000, 0, 0, 16'h0050);
    for (int i = 0; i < 16; i++)
      add(1, 16'h0060, 16'h00A0, 0, 0, 16'h0000, 0, (i == 15), (i == 15) ? 16'h0060 : 16'h0050);
    add(1, 16'h0060, 16'h00A0, 0, 0, 16'h0000, 1, 1, 16'h0060);

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // reset landing mid-calibration must discard the partial sum
    add(0, 16'h0030, 16'h00A0, 0, 1, 16'h0000, 0, 0, 16'h0060);
    apply(tbl[tbl.size()-1], "rc_req");
    for (int i = 0; i < 7; i++) begin
      v = '{1, 16'h0030, 16'h00A0, 0, 0, 16'h0000, 0, 0, 16'h0060};
      apply(v, $sformatf("rc_pre%0d", i));
    end
    rst = 1'b1;
    v = '{1, 16'h0030, 16'h00A0, 0, 0, 16'h0000, 0, 0, 16'h0000};
    apply(v, "rc_rst");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = '{1, (i == 15) ? 16'h002F : 16'h0030, 16'h00A0, 0, 0, 16'h0000, 0,
            (i == 15), (i == 15) ? 16'h002F : 16'h0000};
      apply(v, $sformatf("rc_cal%0d", i));
    end

    v = '{0, 16'h0050, 16'h00A0, 0, 1, 16'h0000, 0, 0, 16'h002F};
    apply(v, "sat_req");
    for (int i = 0; i < 16; i++) begin
      v = '{1, 16'h0050, 16'h00A0, 0, 0, 16'h0000, 0, (i == 15), (i == 15) ? 16'h0050 : 16'h002F};
      apply(v, $sformatf("sat_cal%0d", i));
    end

    // each sample adds 0x8050 * 1 = 32848 integrator LSBs
    m = 0;
    acc_max = (64'sd1 <<< 26) - 1;
    bus.vld = 1'b1; bus.ptch_rt = 16'h8000; bus.AZ = 16'h00A0; bus.fuse_en = 1'b0; bus.cal_req = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk);
      #1;
      m = m + 32848;
`ifdef INERT_SAT_EN
      if (m > acc_max) m = acc_max;
`else
      if (m > acc_max) m = m - (64'sd1 <<< 27);
`endif
      ep = 16'(m >>> 11);
      chk($sformatf("ramp%0d ptch", k), bus.ptch, ep);
      if (k == 2044) begin
`ifdef INERT_SAT_EN
        chk("ramp pinned", bus.ptch, 16'h7FFF);
`else
        chk("ramp wrapped sign", {15'd0, bus.ptch[15]}, 16'h0001);
`endif
      end
    end
`ifdef INERT_SAT_EN
    chk("ramp final", bus.ptch, 16'h7FFF);
`else
    chk("ramp final", bus.ptch, 16'hBBF5);
`endif
    chk("ramp ptch_vld", {15'd0, bus.ptch_vld}, 16'h0001);
    bus.vld = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inertial_integrator_cal.md
Name: inertial_integrator_cal

Overview:
Parametrised successor to the pitch integrator. Integrates bias-compensated gyro pitch rate and fuses it with an accelerometer-derived pitch estimate, as before. Adds run-time gyro bias calibration over 2^CAL_LOG2 samples, an enable for fusion, a per-sample output valid strobe, and optional accumulator saturation. Sits between the inertial sensor interface and the balance controller.

Parameters:
DATA_W, 16, width of ptch_rt, AZ and ptch (signed).
FRAC_W, 11, fractional bits of the integrator; accumulator width ACC_W = DATA_W+FRAC_W.
CAL_LOG2, 8, log2 of the number of valid samples averaged for the gyro bias.
AZ_OFFSET, 16'h00A0, accelerometer bias subtracted from AZ.
AZ_SCALE, 327, small-angle scale factor applied to compensated AZ.
PROD_SHIFT, 13, arithmetic right shift applied to the AZ product.
FUSE_MAG, 1024, magnitude of the fusion correction, in integrator LSBs.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
vld  in  1  new inertial sample is valid this cycle.
ptch_rt  in  DATA_W  signed gyro pitch rate.
AZ  in  DATA_W  signed accelerometer Z reading.
fuse_en  in  1  enable accelerometer fusion.
cal_req  in  1  single-cycle pulse that restarts bias calibration.
ptch  out  DATA_W  signed fused pitch, ptch_int[ACC_W-1:FRAC_W].
ptch_vld  out  1  one-cycle pulse when ptch updates in RUN.
cal_done  out  1  high while in RUN; bias is valid.
bias  out  DATA_W  signed current gyro bias estimate.

Behaviour:
- There is one clock. Reset is synchronous and active-high.
- On reset (rst=1 at a clk edge): state=CAL, ptch_int=0, cal_sum=0, cal_cnt=0, bias=0, ptch=0, ptch_vld=0, cal_done=0. Reset takes priority over all other inputs.
- CAL state:
  - On each vld, cal_sum += sext(ptch_rt) and cal_cnt += 1.
  - cal_sum is DATA_W+CAL_LOG2 bits wide.
  - On the vld that makes cal_cnt reach 2^CAL_LOG2: bias <= cal_sum_next >>> CAL_LOG2 (arithmetic, floor). State goes to RUN with cal_done=1 from the next cycle.
  - ptch_int is held at 0 and ptch_vld stays 0 throughout CAL.
- RUN state:
  - On each vld, compute rt_comp = ptch_rt - bias in DATA_W+1 bits, so the subtraction cannot overflow.
  - acc_p = ((AZ - AZ_OFFSET) * AZ_SCALE) >>> PROD_SHIFT, truncated to DATA_W.
  - fuse = fuse_en ? (acc_p > ptch ? +FUSE_MAG : -FUSE_MAG) : 0. The comparison uses the registered ptch.
  - ptch_int <= ptch_int - sext(rt_comp) + sext(fuse).
  - ptch_vld=1 on the following cycle, so latency is 1 clk. Without vld, everything holds.
- cal_req (any state): next state CAL. Clears cal_sum, cal_cnt and ptch_int; cal_done=0 next cycle. bias keeps its old value until the new calibration completes. If vld arrives in the same cycle as cal_req, that sample is discarded.
- Without the optional feature, the accumulator wraps modulo 2^ACC_W.
- Outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
- INERT_SAT_EN defined: the integrator update is computed in ACC_W+2 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. ptch therefore pins at 0x7FFF / 0x8000 (DATA_W=16).
- INERT_SAT_EN undefined: two's-complement wrap.

Decomposition:
- inertial_pkg holds:
  - the state enum (CAL, RUN);
  - default constants AZ_OFFSET_DEF, AZ_SCALE_DEF, PROD_SHIFT_DEF, FUSE_MAG_DEF;
  - a sat_add function used under INERT_SAT_EN.
- One sub-module, gyro_bias_cal: the sample counter, sum accumulator and bias register, with inputs vld/ptch_rt/clear and outputs bias/done_pulse. The parent owns the FSM, fusion and integrator.

Test Plan (CAL_LOG2=4, defaults otherwise):
1. Reset, then 16 vld with ptch_rt=0x0050, AZ=0x00A0, fuse_en=0 -> cal_done rises 1 clk after the 16th vld; bias=0x0050; 100 further identical vld -> ptch=0, ptch_vld pulses 100 times.
2. After calibration (bias=0x0050), ptch_rt=0x0850, fuse_en=0, one vld -> ptch_int=-2048, ptch=0xFFFF one cycle later, ptch_vld=1 for one cycle.
3. After calibration, ptch_rt=0x0050, AZ=0x10A0 (acc_p=163), fuse_en=1, two vld -> ptch_int=2048, ptch=0x0001; drive AZ=0x00A0 (acc_p=0), two vld -> ptch returns to 0.
4. In RUN with ptch≠0, pulse cal_req together with vld -> sample discarded; ptch=0 and cal_done=0 next cycle; no ptch_vld for the next 16 vld; old bias held until the new bias loads.
5. INERT_SAT_EN, bias=0x0050, ptch_rt=0x8000, vld continuous for 3000 cycles -> ptch saturates at 0x7FFF and stays there. Without the macro, ptch wraps to a negative value after ~2043 samples.
6. Assert rst mid-calibration (after 7 vld) concurrently with vld -> next cycle all outputs are at reset values; calibration needs a full 16 fresh samples.
